// File: rtl/ldpc_pkg.sv
// Shared constants and FSM encoding for the LDPC encoder back end.
package ldpc_pkg;

    localparam int unsigned N_CODE         = 2304;
    localparam int unsigned K_INFO         = 1536;
    localparam int unsigned BEAT_W_DEFAULT = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

endpackage

// File: rtl/codeword_serializer_if.sv
// Capture/stream handshake bundle between encoder, serializer and channel side.
interface codeword_serializer_if #(
    parameter int unsigned N = 2304,
    parameter int unsigned W = 8
);
    logic         load;
    logic [N-1:0] codeword_in;
    logic         load_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_first;
    logic         out_last;
    logic         overrun;

    // Producer/consumer side (encoder plus channel).
    modport master (
        output load, codeword_in, out_ready,
        input  load_ready, out_data, out_valid, out_first, out_last, overrun
    );

    // Serializer side.
    modport slave (
        input  load, codeword_in, out_ready,
        output load_ready, out_data, out_valid, out_first, out_last, overrun
    );
endinterface

// File: rtl/codeword_shift_reg.sv
// N-bit parallel-load register that shifts left by W per beat; top W bits are the beat.
module codeword_shift_reg #(
    parameter int unsigned N = 2304,
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [N-1:0] data_i,
    output logic [W-1:0] top_o
);

    logic [N-1:0] sr_q;

    // Load wins over shift so a new codeword replaces the spent last beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= data_i;
        end else if (shift_i) begin
            sr_q <= sr_q << W;
        end
    end

    assign top_o = sr_q[N-1 -: W];

endmodule

// File: rtl/codeword_serializer.sv
// Captures an N-bit codeword and streams it MSB-first as N/W beats with frame flags.
module codeword_serializer
    import ldpc_pkg::*;
#(
    parameter int unsigned N         = N_CODE,
    parameter int unsigned W         = BEAT_W_DEFAULT,
    parameter int unsigned BEAT_BITS = ((N / W) > 1) ? $clog2(N / W) : 1
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    codeword_serializer_if.slave bus_io
);

    if ((N % W) != 0) begin : g_bad_width
        $error("codeword_serializer: N must be a multiple of W");
    end

    localparam int unsigned          Beats    = N / W;
    localparam logic [BEAT_BITS-1:0] LastBeat = BEAT_BITS'(Beats - 1);

    ser_state_e           state_q, state_d;
    logic [BEAT_BITS-1:0] cnt_q, cnt_d;
    logic                 overrun_q;
    logic                 out_valid, out_last, xfer, accept;

    assign out_valid = (state_q == SEND);
    assign out_last  = out_valid & (cnt_q == LastBeat);
    assign xfer      = out_valid & bus_io.out_ready;

    assign bus_io.load_ready = (state_q == IDLE) | (out_last & bus_io.out_ready);
    assign accept            = bus_io.load & bus_io.load_ready;

    assign bus_io.out_valid = out_valid;
    assign bus_io.out_first = out_valid & (cnt_q == '0);
    assign bus_io.out_last  = out_last;
    assign bus_io.overrun   = overrun_q;

    // A capture on the final transfer reloads instead of shifting.
    codeword_shift_reg #(
        .N (N),
        .W (W)
    ) u_shift_reg (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (accept),
        .shift_i (xfer & ~accept),
        .data_i  (bus_io.codeword_in),
        .top_o   (bus_io.out_data)
    );

    // Next-state and beat counter; a load on the last transfer keeps SEND with no bubble.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus_io.load) begin
                    state_d = SEND;
                    cnt_d   = '0;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (out_last) begin
                        cnt_d   = '0;
                        state_d = bus_io.load ? SEND : IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // State, counter and registered overrun pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            overrun_q <= bus_io.load & ~bus_io.load_ready;
        end
    end

endmodule

// File: tb/tb_codeword_serializer.sv
// Bench for codeword_serializer: N=24/W=4 stream checks plus an N=W single-beat instance.
module tb_codeword_serializer;

    localparam int BEATS = 6;

    typedef struct packed {
        logic [3:0] data;
        logic       first;
        logic       last;
    } beat_t;

    typedef struct {
        string       name;
        logic [23:0] cw;
        logic [5:0]  stall;
        int          exp_cycles;
    } vec_t;

    logic clk = 1'b0;
    logic rst_ni;
    logic mon_en = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    beat_t sb[$];
    vec_t  vecs[4];

    always #5 clk = ~clk;

    codeword_serializer_if #(.N(24), .W(4)) a_if ();
    codeword_serializer_if #(.N(8),  .W(8)) b_if ();

    codeword_serializer #(.N(24), .W(4)) u_dut_a (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus_io (a_if)
    );

    codeword_serializer #(.N(8), .W(8)) u_dut_b (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus_io (b_if)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [23:0] cw);
        beat_t e;
        for (int i = 0; i < BEATS; i++) begin
            e.data  = cw[23 - 4*i -: 4];
            e.first = (i == 0);
            e.last  = (i == BEATS - 1);
            sb.push_back(e);
        end
    endtask

    // Present a codeword for one cycle, assuming the DUT is idle.
    task automatic run_frame(input logic [23:0] cw);
        a_if.load        = 1'b1;
        a_if.codeword_in = cw;
        push_frame(cw);
        step();
        a_if.load = 1'b0;
    endtask

    // Consume beats until out_valid drops, stalling 3 cycles on each beat flagged in mask.
    task automatic drain(input logic [5:0] mask, input int exp_cycles, input string name);
        int cycles = 0;
        int stall_left = 0;
        int b;
        logic [5:0] stalled = '0;
        while (a_if.out_valid === 1'b1 && cycles < 100) begin
            b = BEATS - sb.size();
            if (stall_left > 0) begin
                a_if.out_ready = 1'b0;
                stall_left--;
            end else if (b >= 0 && b < BEATS && mask[b] && !stalled[b]) begin
                stalled[b]     = 1'b1;
                stall_left     = 2;
                a_if.out_ready = 1'b0;
            end else begin
                a_if.out_ready = 1'b1;
            end
            step();
            cycles++;
        end
        a_if.out_ready = 1'b1;
        chk({name, " cycles"}, cycles, exp_cycles);
        chk({name, " idle after"}, {31'b0, a_if.out_valid}, 32'd0);
        chk({name, " queue drained"}, sb.size(), 32'd0);
    endtask

    // Scoreboard: every presented beat must match the head; pop only on transfer.
    always @(negedge clk) begin
        if (mon_en && a_if.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL spurious beat: got data %h, expected no beat", a_if.out_data);
            end else begin
                chk("beat data", {28'b0, a_if.out_data}, {28'b0, sb[0].data});
                chk("beat first", {31'b0, a_if.out_first}, {31'b0, sb[0].first});
                chk("beat last", {31'b0, a_if.out_last}, {31'b0, sb[0].last});
                if (a_if.out_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"basic",       24'hABCDEF, 6'b000000, 6};
        vecs[1] = '{"backpressure", 24'hABCDEF, 6'b010100, 12};
        vecs[2] = '{"alt",         24'h5A3C96, 6'b000001, 9};
        vecs[3] = '{"all stall",   24'hFF00F0, 6'b111111, 24};

        rst_ni           = 1'b1;
        a_if.load        = 1'b0;
        a_if.codeword_in = '0;
        a_if.out_ready   = 1'b1;
        b_if.load        = 1'b0;
        b_if.codeword_in = '0;
        b_if.out_ready   = 1'b1;
        #1 rst_ni = 1'b0;
        #2;
        chk("reset out_valid", {31'b0, a_if.out_valid}, 32'd0);
        chk("reset out_first", {31'b0, a_if.out_first}, 32'd0);
        chk("reset out_last", {31'b0, a_if.out_last}, 32'd0);
        chk("reset out_data", {28'b0, a_if.out_data}, 32'd0);
        chk("reset overrun", {31'b0, a_if.overrun}, 32'd0);
        chk("reset load_ready", {31'b0, a_if.load_ready}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_ni = 1'b1;
        mon_en = 1'b1;
        step();
        chk("idle load_ready", {31'b0, a_if.load_ready}, 32'd1);
        chk("idle out_valid", {31'b0, a_if.out_valid}, 32'd0);

        // Table-driven frames with varied backpressure.
        for (int v = 0; v < 4; v++) begin
            run_frame(vecs[v].cw);
            chk({vecs[v].name, " first beat latency"}, {31'b0, a_if.out_valid}, 32'd1);
            drain(vecs[v].stall, vecs[v].exp_cycles, vecs[v].name);
        end

        // Back-to-back: second codeword held on load until the last beat transfers.
        run_frame(24'hABCDEF);
        a_if.load        = 1'b1;
        a_if.codeword_in = 24'h123456;
        for (int i = 0; i < BEATS; i++) begin
            chk("b2b load_ready", {31'b0, a_if.load_ready}, {31'b0, (i == BEATS - 1)});
            if (i == BEATS - 1) push_frame(24'h123456);
            step();
        end
        a_if.load = 1'b0;
        chk("b2b no gap", {31'b0, a_if.out_valid}, 32'd1);
        chk("b2b first", {31'b0, a_if.out_first}, 32'd1);
        chk("b2b data", {28'b0, a_if.out_data}, 32'h1);
        drain(6'b0, 6, "b2b second");
        step();

        // Overrun: load during beat C is dropped and pulses overrun for one cycle.
        run_frame(24'hABCDEF);
        repeat (2) step();
        a_if.load        = 1'b1;
        a_if.codeword_in = 24'h000FFF;
        step();
        a_if.load = 1'b0;
        chk("overrun pulse", {31'b0, a_if.overrun}, 32'd1);
        step();
        chk("overrun one cycle", {31'b0, a_if.overrun}, 32'd0);
        drain(6'b0, 2, "overrun tail");

        // Reset between edges during beat D.
        run_frame(24'hABCDEF);
        repeat (3) step();
        #2 rst_ni = 1'b0;
        #1;
        chk("midreset out_valid", {31'b0, a_if.out_valid}, 32'd0);
        chk("midreset out_first", {31'b0, a_if.out_first}, 32'd0);
        chk("midreset out_last", {31'b0, a_if.out_last}, 32'd0);
        chk("midreset out_data", {28'b0, a_if.out_data}, 32'd0);
        sb.delete();
        @(negedge clk);
        @(negedge clk) rst_ni = 1'b1;
        step();
        run_frame(24'h0F0F0F);
        drain(6'b0, 6, "post reset");

        // Single-beat configuration.
        b_if.load        = 1'b1;
        b_if.codeword_in = 8'hA5;
        step();
        b_if.load = 1'b0;
        chk("single data", {24'b0, b_if.out_data}, 32'hA5);
        chk("single valid", {31'b0, b_if.out_valid}, 32'd1);
        chk("single first", {31'b0, b_if.out_first}, 32'd1);
        chk("single last", {31'b0, b_if.out_last}, 32'd1);
        chk("single load_ready", {31'b0, b_if.load_ready}, 32'd1);
        step();
        chk("single idle after", {31'b0, b_if.out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/codeword_serializer.md
Name: codeword_serializer

Overview:
Downstream stage of the LDPC encoder. It captures one complete N-bit codeword in parallel, then streams it out as N/W beats of W bits over a valid/ready handshake. It provides frame-boundary flags for the channel/modulator interface. It also accepts a new codeword in the same cycle the last beat of the current one transfers, so back-to-back codewords stream with no bubble.

Parameters:
N, 2304, codeword length in bits
W, 8, output beat width in bits; N mod W must be 0 (elaboration error otherwise)
BEAT_BITS, 9, counter width; ceil(log2(N/W))

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
load  input  1  codeword_in valid; capture request
codeword_in  input  N  parallel codeword from encoder
load_ready  output  1  capture will be accepted this cycle
out_data  output  W  current beat
out_valid  output  1  out_data holds a valid beat
out_ready  input  1  consumer accepts beat
out_first  output  1  current beat is beat 0 of a frame
out_last  output  1  current beat is beat N/W-1 of a frame
overrun  output  1  one-cycle pulse: load asserted while load_ready=0

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, shift register=0, beat_cnt=0, out_valid=0, out_first=0, out_last=0, overrun=0, out_data=0. On release, the block is in IDLE with load_ready=1.
- States:
  - IDLE: out_valid=0, load_ready=1. load=1 -> capture codeword_in, beat_cnt=0, go to SEND.
  - SEND: out_valid=1.
- Capture latency: out_valid rises on the clock edge that samples load (first beat is visible the cycle after load).
- Bit order, MSB first:
  - Beat i carries codeword bits [N-1-i*W : N-W-i*W].
  - out_data[W-1] is the earlier bit on the wire.
- Transfer: occurs when out_valid & out_ready. Then the shift register shifts left by W and beat_cnt increments.
- Stall: while out_valid=1 & out_ready=0, out_data, out_first, out_last and beat_cnt hold stable.
- Flags:
  - out_first = out_valid & (beat_cnt==0).
  - out_last = out_valid & (beat_cnt==N/W-1).
- Frame end: on a transfer with out_last=1:
  - if load=1 in the same cycle -> capture the new codeword, beat_cnt=0, stay in SEND (no idle cycle);
  - otherwise go to IDLE.
- load_ready = (state==IDLE) | (out_last & out_ready), combinational.
- load with load_ready=0: codeword_in is ignored, the current frame is unaffected, and overrun=1 for exactly one cycle (registered).
- Single-beat case: when N/W==1, out_first and out_last are both 1 on the same beat.
- Reset asserted mid-frame: the frame is abandoned immediately and no further beats are emitted.
- out_ready while in IDLE is ignored.

Decomposition:
- Shared package ldpc_pkg holds:
  - code constants N_CODE=2304 and K_INFO=1536;
  - the default beat width;
  - state encoding IDLE=1'b0, SEND=1'b1.
- One natural sub-module: codeword_shift_reg. It is an N-bit parallel-load, shift-by-W register with load/shift enables and async active-low reset, exposing its top W bits.
- The FSM and beat counter stay in the top.

Test Plan:
- Test configuration: N=24, W=4, so 6 beats per frame.
- Basic frame: load codeword_in=24'hABCDEF with out_ready=1 constantly.
  -> out_data = A,B,C,D,E,F on 6 consecutive cycles starting the cycle after load;
  -> out_first only on A, out_last only on F;
  -> out_valid=0 after F.
- Backpressure: same frame, out_ready low on beats 2 and 4 for 3 cycles each.
  -> beat value and flags are held while stalled;
  -> sequence is still A..F, completing after 12 cycles.
- Back-to-back: load 24'h123456 held until the cycle F of 24'hABCDEF transfers.
  -> load_ready=1 in that cycle;
  -> next cycle out_data=1 with out_first=1;
  -> no gap in out_valid.
- Overrun: load 24'h000FFF during beat C.
  -> overrun pulses one cycle;
  -> stream remains C,D,E,F of 24'hABCDEF;
  -> block then returns to IDLE.
- Reset mid-frame: assert rst=0 asynchronously during beat D (between edges).
  -> out_valid, out_first, out_last, out_data are 0 immediately;
  -> after release, load 24'h0F0F0F produces 0,F,0,F,0,F.
- Single-beat config (N=8, W=8): load 8'hA5.
  -> one beat A5 with out_first=out_last=1.
